vga_scan_reader: RTL and testbench



---
 rtl/vga_scan_reader.sv | 167 ++++++++++++++++
 tb/tb_vga_scan_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_reader.sv
// vga_scan_reader
//
// Raster-scan reader for a one-bit-per-pixel framebuffer. It produces VGA
// timing (640x480 at 60 Hz with the default parameters), drives the
// framebuffer read address from the scan counters, and turns the returned
// pixel bit into registered 12-bit RGB. The RGB is aligned with the
// registered active-low sync outputs and the activeVideo flag.
//
// Ports
//   clk          system clock; all state updates on its rising edge
//   reset        synchronous, active-high; takes priority over pixEn
//   pixEn        pixel-rate enable; counters and video outputs move only
//                when it is high
//   color        framebuffer read data for readX/readY (combinational memory)
//   readX[9:0]   framebuffer column, forced to 0 outside the visible columns
//   readY[9:0]   framebuffer row, forced to 0 outside the visible lines
//   vgaR/G/B     registered 4-bit colour channels
//   hsync_n      registered horizontal sync, active low
//   vsync_n      registered vertical sync, active low
//   activeVideo  registered; high while RGB carries visible pixels
//   frameStart   one-clk pulse when the counters wrap to (0,0)
//
// Flow control: pixEn is a plain qualifier with no backpressure. A cycle
// with pixEn=1 consumes exactly one pixel slot: the counters step and the
// output stage captures the pixel addressed by the counters before the step.
// On pixEn=0 cycles everything holds, except frameStart, which drops to 0.
//
// The horizontal and vertical totals must fit in the 10-bit counters
// (at most 1024 each).

module vga_scan_reader #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic [11:0] FG_RGB   = 12'hFFF,
  parameter logic [11:0] BG_RGB   = 12'h000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixEn,
  input  logic       color,
  output logic [9:0] readX,
  output logic [9:0] readY,
  output logic [3:0] vgaR,
  output logic [3:0] vgaG,
  output logic [3:0] vgaB,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       activeVideo,
  output logic       frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter-width copies of the timing boundaries, so every comparison
  // below is between equal-width operands.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Scan counters and their next values
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic [9:0]  h_next;
  logic [9:0]  v_next;
  logic        h_wrap;
  logic        v_wrap;

  // Decoded position of the current counter value
  logic        h_visible;
  logic        v_visible;
  logic        visible;
  logic        h_sync_on;
  logic        v_sync_on;
  logic [11:0] pix_rgb;

  // Registered output stage
  logic [11:0] rgb_q;

  // ---------------------------------------------------------------------
  // Counter next-state
  // ---------------------------------------------------------------------
  assign h_wrap = (h_count == H_LAST);
  assign v_wrap = (v_count == V_LAST);

  always_comb begin
    h_next = h_count;
    v_next = v_count;
    if (pixEn) begin
      if (h_wrap) begin
        h_next = '0;
        // The line counter moves only when the pixel counter wraps.
        v_next = v_wrap ? '0 : v_count + 10'd1;
      end else begin
        h_next = h_count + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else begin
      h_count <= h_next;
      v_count <= v_next;
    end
  end

  // ---------------------------------------------------------------------
  // Position decode and read address
  // ---------------------------------------------------------------------
  assign h_visible = (h_count < H_VIS);
  assign v_visible = (v_count < V_VIS);
  assign visible   = h_visible & v_visible;

  assign h_sync_on = (h_count >= HS_START) && (h_count < HS_END);
  assign v_sync_on = (v_count >= VS_START) && (v_count < VS_END);

  // The address is clamped to 0 during blanking, so the framebuffer index
  // never leaves the visible 640x480 area.
  assign readX = h_visible ? h_count : '0;
  assign readY = v_visible ? v_count : '0;

  // Blanking always outputs black, whatever the memory returns.
  assign pix_rgb = visible ? (color ? FG_RGB : BG_RGB) : 12'h000;

  // ---------------------------------------------------------------------
  // Output stage: one pixel slot behind the counters, so RGB, syncs and
  // activeVideo all describe the same pixel.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q       <= 12'h000;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      activeVideo <= 1'b0;
      frameStart  <= 1'b0;
    end else begin
      // Set only on the enabled step from the last pixel of the frame to
      // (0,0); any other cycle, including pixEn=0 cycles, clears it.
      frameStart <= pixEn & h_wrap & v_wrap;
      if (pixEn) begin
        rgb_q       <= pix_rgb;
        hsync_n     <= ~h_sync_on;
        vsync_n     <= ~v_sync_on;
        activeVideo <= visible;
      end
    end
  end

  assign vgaR = rgb_q[11:8];
  assign vgaG = rgb_q[7:4];
  assign vgaB = rgb_q[3:0];

endmodule

// File: tb/tb_vga_scan_reader.sv
// tb_vga_scan_reader
//
// Bench for vga_scan_reader. Two instances share clk/reset/pixEn:
//   dut_d : default 640x480 timing (line-level behaviour, colour mapping)
//   dut_s : a small raster (35x21 totals) so whole frames fit in a short run
// Each instance gets its own framebuffer read port from a shared bitmap.
// The reference model describes the scan purely by the number k of enabled
// pixel steps since reset: counters are at (k mod HT, (k div HT) mod VT),
// outputs describe position k-1, and frameStart marks k being a multiple of
// the frame length.

module tb_vga_scan_reader;

  // ---------------------------------------------------------------------
  // Clock / reset / shared inputs
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset    = 1'b1;
  logic pixEn    = 1'b0;
  logic color_d  = 1'b0;
  logic color_s  = 1'b0;
  logic color_or = 1'b0;

  logic [9:0] readX_d, readY_d, readX_s, readY_s;
  logic [3:0] vgaR_d, vgaG_d, vgaB_d, vgaR_s, vgaG_s, vgaB_s;
  logic       hsync_n_d, vsync_n_d, activeVideo_d, frameStart_d;
  logic       hsync_n_s, vsync_n_s, activeVideo_s, frameStart_s;

  vga_scan_reader dut_d (
    .clk(clk), .reset(reset), .pixEn(pixEn), .color(color_d),
    .readX(readX_d), .readY(readY_d),
    .vgaR(vgaR_d), .vgaG(vgaG_d), .vgaB(vgaB_d),
    .hsync_n(hsync_n_d), .vsync_n(vsync_n_d),
    .activeVideo(activeVideo_d), .frameStart(frameStart_d)
  );

  vga_scan_reader #(
    .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(12), .V_FP(3), .V_SYNC(2), .V_BP(4),
    .FG_RGB(12'hA5C), .BG_RGB(12'h321)
  ) dut_s (
    .clk(clk), .reset(reset), .pixEn(pixEn), .color(color_s),
    .readX(readX_s), .readY(readY_s),
    .vgaR(vgaR_s), .vgaG(vgaG_s), .vgaB(vgaB_s),
    .hsync_n(hsync_n_s), .vsync_n(vsync_n_s),
    .activeVideo(activeVideo_s), .frameStart(frameStart_s)
  );

  logic [35:0] word_d, word_s;
  assign word_d = {readX_d, readY_d, vgaR_d, vgaG_d, vgaB_d,
                   hsync_n_d, vsync_n_d, activeVideo_d, frameStart_d};
  assign word_s = {readX_s, readY_s, vgaR_s, vgaG_s, vgaB_s,
                   hsync_n_s, vsync_n_s, activeVideo_s, frameStart_s};

  // ---------------------------------------------------------------------
  // Framebuffer and reference model
  // ---------------------------------------------------------------------
  bit fb_mem [0:479][0:639];

  typedef struct {
    int          ha, hfp, hs, hbp, va, vfp, vs, vbp;
    logic [11:0] fg, bg;
  } timing_t;

  timing_t t_d, t_s;

  int k_d, k_s;
  bit c_d, c_s, fs_d, fs_s;

  function automatic bit fb_pix(input int x, input int y);
    if (x >= 0 && x < 640 && y >= 0 && y < 480) return fb_mem[y][x];
    return 1'b0;
  endfunction

  function automatic int h_tot(input timing_t t);
    return t.ha + t.hfp + t.hs + t.hbp;
  endfunction

  function automatic int v_tot(input timing_t t);
    return t.va + t.vfp + t.vs + t.vbp;
  endfunction

  // Pixel bit the memory returns while the scan sits at step k
  function automatic bit fb_at(input timing_t t, input int k);
    int h, v;
    h = k % h_tot(t);
    v = (k / h_tot(t)) % v_tot(t);
    return fb_pix((h < t.ha) ? h : 0, (v < t.va) ? v : 0);
  endfunction

  // Expected output word after k enabled steps; c is the pixel bit sampled
  // on the last step, fs the expected frameStart.
  function automatic logic [35:0] model_out(input timing_t t, input int k,
                                            input bit c, input bit fs);
    int ht, vt, h, v, ph, pv;
    logic [9:0]  rx, ry;
    logic [11:0] rgb;
    bit hs_n, vs_n, av;
    ht   = h_tot(t);
    vt   = v_tot(t);
    h    = k % ht;
    v    = (k / ht) % vt;
    rx   = 10'((h < t.ha) ? h : 0);
    ry   = 10'((v < t.va) ? v : 0);
    rgb  = 12'h000;
    hs_n = 1'b1;
    vs_n = 1'b1;
    av   = 1'b0;
    if (k > 0) begin
      ph   = (k - 1) % ht;
      pv   = ((k - 1) / ht) % vt;
      av   = (ph < t.ha) && (pv < t.va);
      rgb  = av ? (c ? t.fg : t.bg) : 12'h000;
      hs_n = !((ph >= t.ha + t.hfp) && (ph < t.ha + t.hfp + t.hs));
      vs_n = !((pv >= t.va + t.vfp) && (pv < t.va + t.vfp + t.vs));
    end
    return {rx, ry, rgb, hs_n, vs_n, av, fs};
  endfunction

  task automatic model_edge(input timing_t t, input bit rst, input bit en,
                            input bit cor, inout int k, inout bit c,
                            output bit fs);
    fs = 1'b0;
    if (rst) begin
      k = 0;
      c = 1'b0;
    end else if (en) begin
      c  = fb_at(t, k) | cor;
      k  = k + 1;
      fs = ((k % (h_tot(t) * v_tot(t))) == 0);
    end
  endtask

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  logic [71:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_word(input string p, input logic [35:0] got,
                              input logic [35:0] exp);
    check({p, "readX"},       32'(got[35:26]), 32'(exp[35:26]));
    check({p, "readY"},       32'(got[25:16]), 32'(exp[25:16]));
    check({p, "rgb"},         32'(got[15:4]),  32'(exp[15:4]));
    check({p, "hsync_n"},     32'(got[3]),     32'(exp[3]));
    check({p, "vsync_n"},     32'(got[2]),     32'(exp[2]));
    check({p, "activeVideo"}, 32'(got[1]),     32'(exp[1]));
    check({p, "frameStart"},  32'(got[0]),     32'(exp[0]));
  endtask

  // Per-phase observations of the DUT outputs
  int cyc, hs_low_d, first_hs_d, av_d, fg_d, blank_rgb_d, y1_idx_d;
  int fs_cnt_s, vs_low_s, fs_run_s;
  int max_fs_run = 0;

  task automatic clear_stats();
    cyc = 0; hs_low_d = 0; first_hs_d = 0; av_d = 0; fg_d = 0;
    blank_rgb_d = 0; y1_idx_d = 0; fs_cnt_s = 0; vs_low_s = 0; fs_run_s = 0;
  endtask

  task automatic update_stats();
    cyc++;
    if (!hsync_n_d) begin
      hs_low_d++;
      if (first_hs_d == 0) first_hs_d = cyc;
    end
    if (activeVideo_d) av_d++;
    if ({vgaR_d, vgaG_d, vgaB_d} == 12'hFFF) fg_d++;
    if (!activeVideo_d && ({vgaR_d, vgaG_d, vgaB_d} != 12'h000)) blank_rgb_d++;
    if (readY_d == 10'd1 && y1_idx_d == 0) y1_idx_d = cyc;
    if (frameStart_s) fs_cnt_s++;
    if (!vsync_n_s) vs_low_s++;
    fs_run_s = frameStart_s ? fs_run_s + 1 : 0;
    if (fs_run_s > max_fs_run) max_fs_run = fs_run_s;
  endtask

  // ---------------------------------------------------------------------
  // Driver: one clk cycle, called at the falling edge
  // ---------------------------------------------------------------------
  task automatic cycle(input bit rst, input bit en, input bit cor);
    logic [71:0] exp_w;
    reset    = rst;
    pixEn    = en;
    color_or = cor;
    // Framebuffer read port: data for the address currently presented
    color_d  = fb_pix(int'(readX_d), int'(readY_d)) | cor;
    color_s  = fb_pix(int'(readX_s), int'(readY_s)) | cor;
    model_edge(t_d, rst, en, cor, k_d, c_d, fs_d);
    model_edge(t_s, rst, en, cor, k_s, c_s, fs_s);
    exp_q.push_back({model_out(t_d, k_d, c_d, fs_d),
                     model_out(t_s, k_s, c_s, fs_s)});
    @(negedge clk);
    exp_w = exp_q.pop_front();
    compare_word("d.", word_d, exp_w[71:36]);
    compare_word("s.", word_s, exp_w[35:0]);
    update_stats();
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    t_d = '{ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 10, vs: 2, vbp: 33,
             fg: 12'hFFF, bg: 12'h000};
    t_s = '{ha: 20, hfp: 4, hs: 6, hbp: 5, va: 12, vfp: 3, vs: 2, vbp: 4,
             fg: 12'hA5C, bg: 12'h321};
    k_d = 0; k_s = 0; c_d = 0; c_s = 0; fs_d = 0; fs_s = 0;

    // Framebuffer with a single set pixel at column 5, row 3
    for (int y = 0; y < 480; y++)
      for (int x = 0; x < 640; x++)
        fb_mem[y][x] = 1'b0;
    fb_mem[3][5] = 1'b1;

    // Reset held for 3 cycles with pixEn high
    clear_stats();
    repeat (3) cycle(1'b1, 1'b1, 1'b0);

    // Four default lines with pixEn tied high
    clear_stats();
    repeat (3200) cycle(1'b0, 1'b1, 1'b0);
    check("hsync_low_cycles", 32'(hs_low_d), 32'(4 * 96));
    check("hsync_first_low",  32'(first_hs_d), 32'd657);
    check("active_cycles",    32'(av_d), 32'(4 * 640));
    check("fg_pixel_count",   32'(fg_d), 32'd1);
    check("s_frame_pulses",   32'(fs_cnt_s), 32'd4);
    check("s_vsync_low",      32'(vs_low_s), 32'(4 * 2 * 35));

    // One line with the memory forcing color=1: blanking must stay black
    clear_stats();
    repeat (800) cycle(1'b0, 1'b1, 1'b1);
    check("blank_rgb_nonzero", 32'(blank_rgb_d), 32'd0);
    check("forced_fg_count",   32'(fg_d), 32'd640);

    // Stall: pixEn alternating 0,1 after a reset, one full default line
    cycle(1'b1, 1'b1, 1'b0);
    clear_stats();
    for (int i = 1; i <= 1600; i++) cycle(1'b0, (i % 2) == 0, 1'b0);
    check("stalled_line_clks", 32'(y1_idx_d), 32'd1600);
    check("s_stall_pulses",    32'(fs_cnt_s), 32'd1);

    // Reset on the cycle that would otherwise wrap the small frame
    for (int i = 0; i < 800; i++) begin
      if ((k_s % 735) == 734) break;
      cycle(1'b0, 1'b1, 1'b0);
    end
    check("s_at_last_pixel", 32'(readX_s), 32'd0);
    cycle(1'b1, 1'b1, 1'b0);
    check("reset_no_framestart", 32'(frameStart_s), 32'd0);
    check("reset_readX", 32'(readX_d), 32'd0);

    // Timing after the mid-frame reset repeats the post-reset run
    clear_stats();
    repeat (3200) cycle(1'b0, 1'b1, 1'b0);
    check("re_hsync_low_cycles", 32'(hs_low_d), 32'(4 * 96));
    check("re_hsync_first_low",  32'(first_hs_d), 32'd657);
    check("re_fg_pixel_count",   32'(fg_d), 32'd1);
    check("re_s_frame_pulses",   32'(fs_cnt_s), 32'd4);

    // Random bitmap, random enable, occasional forced colour and reset
    for (int y = 0; y < 480; y++)
      for (int x = 0; x < 640; x++)
        fb_mem[y][x] = 1'($urandom_range(0, 1));
    clear_stats();
    for (int i = 0; i < 12000; i++)
      cycle($urandom_range(0, 1999) == 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0);
    check("framestart_width", 32'(max_fs_run), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
